// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and
// default memory latency.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    // Memory latency in cycles from mem_en to mem_rdata valid.
    localparam int MEM_LAT_DEFAULT = 2;

    // Wait counter width; covers latencies 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker. With both requests present the port
// that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Pick a winner from the current request vector
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port fixed-latency data memory.
// Port 0 is the CPU data port, port 1 a secondary master (debug/DMA loader).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no access in flight; arbitrate and latch the winner
// ARB_ACCESS | mem_en strobe with latched addr/wdata/byteen
// ARB_WAIT   | counting down the remaining memory latency
// ARB_RESP   | mem_rdata valid; ack the winner and capture read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_stall,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;
    logic             gnt_id;
    logic [29:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_byteen;
    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;

    logic             arb_gnt;
    logic             arb_valid;
    logic             is_read;

    // Byte offset bits never reach the memory; alignment is checked upstream.
    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .last  (last_gnt),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign is_read = (lat_byteen == 4'b0000);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (arb_valid) state_nxt = ARB_ACCESS;
            ARB_ACCESS: state_nxt = (MEM_LAT == 1) ? ARB_RESP : ARB_WAIT;
            ARB_WAIT:   if (cnt == CNT_W'(1)) state_nxt = ARB_RESP;
            ARB_RESP:   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Grant latch, wait counter and per-port read data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            last_gnt   <= 1'b1;
            gnt_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_byteen <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        gnt_id   <= arb_gnt;
                        last_gnt <= arb_gnt;
                        if (arb_gnt) begin
                            lat_addr   <= m1_addr[31:2];
                            lat_wdata  <= m1_wdata;
                            lat_byteen <= m1_byteen;
                        end else begin
                            lat_addr   <= m0_addr[31:2];
                            lat_wdata  <= m0_wdata;
                            lat_byteen <= m0_byteen;
                        end
                    end
                end
                ARB_ACCESS: cnt <= CNT_LOAD;
                ARB_WAIT:   cnt <= cnt - CNT_W'(1);
                ARB_RESP: begin
                    if (is_read) begin
                        if (gnt_id) rdata1_q <= mem_rdata;
                        else        rdata0_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobe, acks and read data; read data passes straight through in
    // the ack cycle so the requester sees it together with ack.
    always_comb begin
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        m0_rdata   = rdata0_q;
        m1_rdata   = rdata1_q;
        if (state == ARB_ACCESS) begin
            mem_en     = 1'b1;
            mem_addr   = {lat_addr, 2'b00};
            mem_wdata  = lat_wdata;
            mem_byteen = lat_byteen;
        end
        if (state == ARB_RESP) begin
            if (gnt_id) begin
                m1_ack = 1'b1;
                if (is_read) m1_rdata = mem_rdata;
            end else begin
                m0_ack = 1'b1;
                if (is_read) m0_rdata = mem_rdata;
            end
        end
    end

    assign m0_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: main instance at MEM_LAT=2 with a delay-line
// memory model, plus MEM_LAT=1 and MEM_LAT=5 instances for latency checks.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic [3:0]  m0_byteen = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m0_stall;
    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_byteen = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;

    // memory model: returns next_rdata exactly two cycles after mem_en
    logic [31:0] next_rdata = '0;
    logic [1:0]  vld = '0;
    logic [31:0] dat [2] = '{32'h0, 32'h0};

    always @(posedge clk) begin
        vld    <= {vld[0], mem_en};
        dat[0] <= next_rdata;
        dat[1] <= dat[0];
    end
    assign mem_rdata = vld[1] ? dat[1] : 32'h0BAD_0BAD;

    // MEM_LAT=1 and MEM_LAT=5 instances
    logic        q1_req = 1'b0, q5_req = 1'b0;
    logic [31:0] q1_rdata, q5_rdata, q1_r1, q5_r1;
    logic        q1_ack, q5_ack, q1_stall, q5_stall, q1_ack1, q5_ack1;
    logic        q1_en, q5_en;
    logic [31:0] q1_maddr, q5_maddr, q1_mwdata, q5_mwdata;
    logic [3:0]  q1_mbe, q5_mbe;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset),
        .m0_req(q1_req), .m0_addr(32'h40), .m0_wdata(32'h0), .m0_byteen(4'h0),
        .m0_rdata(q1_rdata), .m0_ack(q1_ack), .m0_stall(q1_stall),
        .m1_req(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_byteen(4'h0),
        .m1_rdata(q1_r1), .m1_ack(q1_ack1),
        .mem_en(q1_en), .mem_addr(q1_maddr), .mem_wdata(q1_mwdata),
        .mem_byteen(q1_mbe), .mem_rdata(32'h1111_1111)
    );

    dmem_arbiter #(.MEM_LAT(5)) dut_lat5 (
        .clk(clk), .reset(reset),
        .m0_req(q5_req), .m0_addr(32'h50), .m0_wdata(32'h0), .m0_byteen(4'h0),
        .m0_rdata(q5_rdata), .m0_ack(q5_ack), .m0_stall(q5_stall),
        .m1_req(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_byteen(4'h0),
        .m1_rdata(q5_r1), .m1_ack(q5_ack1),
        .mem_en(q5_en), .mem_addr(q5_maddr), .mem_wdata(q5_mwdata),
        .mem_byteen(q5_mbe), .mem_rdata(32'h5555_5555)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance until either ack, bounded; cycles=0 means timeout
    task automatic wait_ack(output int cycles, output int id);
        cycles = 0;
        id     = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m0_ack || m1_ack) begin
                cycles = i;
                id     = m1_ack ? 1 : 0;
                break;
            end
        end
    endtask

    initial begin
        int cyc, id, en_cnt, c1, c5;
        logic [31:0] tmp;

        // reset state
        #12;
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_ack", {30'b0, m1_ack, m0_ack}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        tick();
        tick();

        // 1: m0 read at 0x3004
        next_rdata = 32'hDEAD_BEEF;
        m0_addr = 32'h0000_3004; m0_byteen = 4'h0; m0_req = 1'b1;
        #1;
        chk("t1_stall_t", {31'b0, m0_stall}, 32'h1);
        tick();
        chk("t1_mem_en_t1", {31'b0, mem_en}, 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h0000_3004);
        chk("t1_mem_byteen", {28'b0, mem_byteen}, 32'h0);
        chk("t1_stall_t1", {31'b0, m0_stall}, 32'h1);
        tick();
        chk("t1_mem_en_t2", {31'b0, mem_en}, 32'h0);
        chk("t1_ack_t2", {31'b0, m0_ack}, 32'h0);
        chk("t1_stall_t2", {31'b0, m0_stall}, 32'h1);
        tick();
        chk("t1_ack_t3", {31'b0, m0_ack}, 32'h1);
        chk("t1_rdata_t3", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_stall_t3", {31'b0, m0_stall}, 32'h0);
        m0_req = 1'b0;
        tick();
        chk("t1_ack_t4", {31'b0, m0_ack}, 32'h0);
        chk("t1_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // 2: simultaneous requests after reset alternate starting with m0
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        next_rdata = 32'h2222_0000;
        m0_addr = 32'h10; m1_addr = 32'h20; m1_byteen = 4'h0;
        m0_req = 1'b1; m1_req = 1'b1;
        wait_ack(cyc, id);
        chk("t2_first_id", 32'(id), 32'd0);
        chk("t2_first_lat", 32'(cyc), 32'd3);
        wait_ack(cyc, id);
        chk("t2_second_id", 32'(id), 32'd1);
        chk("t2_second_gap", 32'(cyc), 32'd4);
        chk("t2_m1_rdata", m1_rdata, 32'h2222_0000);
        wait_ack(cyc, id);
        chk("t2_third_id", 32'(id), 32'd0);
        wait_ack(cyc, id);
        chk("t2_fourth_id", 32'(id), 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // 3: m1 write to misaligned 0x103
        next_rdata = 32'h3333_3333;
        m1_addr = 32'h0000_0103; m1_byteen = 4'b1000; m1_wdata = 32'hAB00_0000;
        m1_req = 1'b1;
        en_cnt = 0;
        tick();
        chk("t3_mem_addr", mem_addr, 32'h0000_0100);
        chk("t3_mem_wdata", mem_wdata, 32'hAB00_0000);
        chk("t3_mem_byteen", {28'b0, mem_byteen}, 32'h8);
        en_cnt += int'(mem_en);
        tick();
        en_cnt += int'(mem_en);
        tick();
        en_cnt += int'(mem_en);
        chk("t3_m1_ack", {31'b0, m1_ack}, 32'h1);
        chk("t3_m1_rdata_kept", m1_rdata, 32'h2222_0000);
        chk("t3_en_pulses", 32'(en_cnt), 32'd1);
        m1_req = 1'b0; m1_byteen = 4'h0;
        tick();

        // 6: back-to-back m0 reads, req held after ack
        next_rdata = 32'h6666_0001;
        m0_addr = 32'h200; m0_req = 1'b1;
        wait_ack(cyc, id);
        chk("t6_first_lat", 32'(cyc), 32'd3);
        chk("t6_first_rdata", m0_rdata, 32'h6666_0001);
        next_rdata = 32'h6666_0002;
        tick();
        chk("t6_en_ack_p1", {31'b0, mem_en}, 32'h0);
        tick();
        chk("t6_en_ack_p2", {31'b0, mem_en}, 32'h1);
        wait_ack(cyc, id);
        chk("t6_second_lat", 32'(cyc), 32'd2);
        chk("t6_second_rdata", m0_rdata, 32'h6666_0002);
        m0_req = 1'b0;
        tick();

        // 4: reset in WAIT abandons the access
        next_rdata = 32'h4444_4444;
        m0_addr = 32'h300; m0_req = 1'b1;
        tick();
        chk("t4_access", {31'b0, mem_en}, 32'h1);
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("t4_rst_en", {31'b0, mem_en}, 32'h0);
        chk("t4_rst_ack", {30'b0, m1_ack, m0_ack}, 32'h0);
        chk("t4_rst_rdata", m0_rdata, 32'h0);
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_cnt += int'(m0_ack) + int'(mem_en);
        end
        chk("t4_quiet_in_reset", 32'(en_cnt), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("t4_restart_en", {31'b0, mem_en}, 32'h1);
        chk("t4_restart_addr", mem_addr, 32'h300);
        tick();
        tick();
        chk("t4_restart_ack", {31'b0, m0_ack}, 32'h1);
        chk("t4_restart_rdata", m0_rdata, 32'h4444_4444);
        m0_req = 1'b0;
        tick();

        // 5: MEM_LAT=1 and MEM_LAT=5 latency
        q1_req = 1'b1; q5_req = 1'b1;
        c1 = 0; c5 = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                tmp = {30'b0, q5_en, q1_en};
                chk("t5_mem_en_t1", tmp, 32'h3);
            end
            if (q1_ack && c1 == 0) begin
                c1 = i; q1_req = 1'b0;
                chk("t5_lat1_rdata", q1_rdata, 32'h1111_1111);
            end
            if (q5_ack && c5 == 0) begin
                c5 = i; q5_req = 1'b0;
                chk("t5_lat5_rdata", q5_rdata, 32'h5555_5555);
            end
        end
        chk("t5_lat1_ack", 32'(c1), 32'd2);
        chk("t5_lat5_ack", 32'(c5), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
